// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one PC, one outstanding memory request,
// single-entry output buffer toward decode, redirect with stale-response drop.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        drop_q, drop_d;

    logic        in_req;
    logic        in_wait;
    logic        in_hold;
    logic [31:0] redir_tgt;
    logic [31:0] pc_inc;
    logic        out_fire;

    assign in_req    = (state_q == S_REQ);
    assign in_wait   = (state_q == S_WAIT);
    assign in_hold   = (state_q == S_HOLD);
    assign redir_tgt = {redirect_pc[31:2], 2'b00};
    assign pc_inc    = pc_q + 32'd4;

    assign mem_req_valid = in_req;
    assign mem_req_addr  = pc_q;

    // A redirect in HOLD kills the presented instruction in the same cycle.
    assign out_valid = in_hold & ~redirect_valid;
    assign out_pc    = pc_q;
    assign out_inst  = inst_q;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        drop_d  = drop_q;
        case (state_q)
            S_REQ: begin
                if (redirect_valid) begin
                    pc_d = redir_tgt;
                end
                if (mem_req_ready) begin
                    state_d = S_WAIT;
                    // The accepted request carries the old PC; its data is stale.
                    drop_d  = redirect_valid;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_d = redir_tgt;
                end
                if (mem_resp_valid) begin
                    if (drop_q || redirect_valid) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        inst_d  = mem_resp_data;
                        state_d = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    drop_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redir_tgt;
                    state_d = S_REQ;
                end else if (out_fire) begin
                    pc_d    = pc_inc;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
                drop_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            inst_q  <= 32'd0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios, then random traffic checked
// against a PC-sequence model and an address-keyed memory model.
module tb_ifu_fetch;

    logic        clock;
    logic        reset_n;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        out_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        req_v0, ov0, req_v1, ov1;
    logic [31:0] req_a0, opc0, oi0, req_a1, opc1, oi1;

    int total = 0;
    int bad   = 0;

    ifu_fetch dut0 (
        .clock(clock), .reset_n(reset_n),
        .mem_req_valid(req_v0), .mem_req_ready(mem_req_ready),
        .mem_req_addr(req_a0),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .out_valid(ov0), .out_ready(out_ready),
        .out_pc(opc0), .out_inst(oi0),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    ifu_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
        .clock(clock), .reset_n(reset_n),
        .mem_req_valid(req_v1), .mem_req_ready(mem_req_ready),
        .mem_req_addr(req_a1),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .out_valid(ov1), .out_ready(out_ready),
        .out_pc(opc1), .out_inst(oi1),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5C3_0F13;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rdy, input logic rv,
                         input logic [31:0] rd, input logic ordy,
                         input logic redir, input logic [31:0] rpc);
        @(negedge clock);
        mem_req_ready  = rdy;
        mem_resp_valid = rv;
        mem_resp_data  = rd;
        out_ready      = ordy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    endtask

    logic [31:0] exp_pc, p_addr, st_pc, st_inst, rpc, rd;
    logic        p_valid, st_valid, rdy, rv, ordy, redir, acc, hs;
    int          p_left, nhs, stall;

    initial begin
        reset_n        = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'd0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        repeat (2) @(negedge clock);
        #1;
        chk("rst_req_v", req_v0, 1);
        chk("rst_req_a", req_a0, 32'h8000_0000);
        chk("rst_out_v", ov0, 0);
        chk("rst_out_pc", opc0, 32'h8000_0000);
        chk("rst_out_inst", oi0, 0);
        chk("rst_req_a_wrap", req_a1, 32'hFFFF_FFFC);
        @(negedge clock);
        reset_n = 1'b1;

        // Basic fetch, minimum latency
        drive(1, 0, 0, 0, 0, 0);
        chk("t1_req_v", req_v0, 1);
        chk("t1_req_a", req_a0, 32'h8000_0000);
        drive(0, 1, 32'h13, 0, 0, 0);
        chk("t1_wait_req_v", req_v0, 0);
        chk("t1_wait_out_v", ov0, 0);
        drive(0, 0, 0, 1, 0, 0);
        chk("t1_out_v", ov0, 1);
        chk("t1_out_pc", opc0, 32'h8000_0000);
        chk("t1_out_inst", oi0, 32'h13);
        chk("t1_wrap_pc", opc1, 32'hFFFF_FFFC);
        idle();
        chk("t1_next_req_v", req_v0, 1);
        chk("t1_next_addr", req_a0, 32'h8000_0004);
        chk("wrap_next_addr", req_a1, 32'h0000_0000);

        // Decode stall in HOLD
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 32'h0010_0093, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            idle();
            chk("stall_out_v", ov0, 1);
            chk("stall_out_pc", opc0, 32'h8000_0004);
            chk("stall_out_inst", oi0, 32'h0010_0093);
            chk("stall_req_v", req_v0, 0);
        end
        drive(0, 0, 0, 1, 0, 0);
        chk("stall_acc_v", ov0, 1);
        idle();
        chk("stall_next_addr", req_a0, 32'h8000_0008);

        // Redirect in WAIT, stale response later
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 32'h8000_0100);
        chk("rw_req_v", req_v0, 0);
        for (int i = 0; i < 2; i++) begin
            idle();
            chk("rw_gap_req_v", req_v0, 0);
            chk("rw_gap_out_v", ov0, 0);
        end
        drive(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
        chk("rw_stale_out_v", ov0, 0);
        idle();
        chk("rw_req_v2", req_v0, 1);
        chk("rw_addr", req_a0, 32'h8000_0100);
        chk("rw_out_v2", ov0, 0);
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 32'h11, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        chk("rw_out_pc", opc0, 32'h8000_0100);
        chk("rw_out_inst", oi0, 32'h11);

        // Redirect in HOLD with out_ready
        drive(1, 0, 0, 0, 0, 0);
        chk("rh_addr0", req_a0, 32'h8000_0104);
        drive(0, 1, 32'h22, 0, 0, 0);
        drive(0, 0, 0, 1, 1, 32'h8000_0200);
        chk("rh_out_v", ov0, 0);
        idle();
        chk("rh_req_v", req_v0, 1);
        chk("rh_addr", req_a0, 32'h8000_0200);

        // Redirect in REQ without handshake, low bits forced
        drive(0, 0, 0, 0, 1, 32'h8000_0301);
        chk("rq_addr_same", req_a0, 32'h8000_0200);
        idle();
        chk("rq_req_v", req_v0, 1);
        chk("rq_addr", req_a0, 32'h8000_0300);

        // Redirect coincident with request acceptance
        drive(1, 0, 0, 0, 1, 32'h8000_0400);
        drive(0, 1, 32'h33, 0, 0, 0);
        chk("ra_req_v", req_v0, 0);
        idle();
        chk("ra_req_v2", req_v0, 1);
        chk("ra_addr", req_a0, 32'h8000_0400);
        chk("ra_out_v", ov0, 0);

        // Redirect and response in the same WAIT cycle
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 32'h44, 0, 1, 32'h8000_0500);
        chk("rr_req_v", req_v0, 0);
        idle();
        chk("rr_req_v2", req_v0, 1);
        chk("rr_addr", req_a0, 32'h8000_0500);
        chk("rr_out_v", ov0, 0);

        // Reset pulse during WAIT, late response ignored
        drive(1, 0, 0, 0, 0, 0);
        idle();
        reset_n = 1'b0;
        #1;
        chk("mr_req_v", req_v0, 1);
        chk("mr_addr", req_a0, 32'h8000_0000);
        chk("mr_out_v", ov0, 0);
        chk("mr_out_pc", opc0, 32'h8000_0000);
        chk("mr_out_inst", oi0, 0);
        @(negedge clock);
        reset_n = 1'b1;
        drive(0, 1, 32'h55, 0, 0, 0);
        chk("mr_late_addr", req_a0, 32'h8000_0000);
        idle();
        chk("mr_late_req_v", req_v0, 1);
        chk("mr_late_out_v", ov0, 0);
        chk("mr_late_inst", oi0, 0);

        // Random traffic against the model
        exp_pc   = 32'h8000_0000;
        p_valid  = 1'b0;
        p_left   = 0;
        p_addr   = 32'd0;
        st_valid = 1'b0;
        st_pc    = 32'd0;
        st_inst  = 32'd0;
        nhs      = 0;
        stall    = 0;
        for (int c = 0; c < 3000; c++) begin
            rdy   = 1'($urandom_range(0, 1));
            ordy  = ($urandom_range(0, 2) != 0);
            redir = ($urandom_range(0, 19) == 0);
            rpc   = 32'h8000_0000 + 32'($urandom_range(0, 4095));
            rd    = $urandom;
            rv    = 1'b0;
            if (p_valid && p_left == 0) begin
                rv = 1'b1;
                rd = memf(p_addr);
            end else if (!p_valid && $urandom_range(0, 7) == 0) begin
                rv = 1'b1;
            end
            drive(rdy, rv, rd, ordy, redir, rpc);

            if (redir) chk("r_redir_kill", ov0, 0);
            if (p_valid) begin
                chk("r_one_outst", req_v0, 0);
                chk("r_wait_out_v", ov0, 0);
            end
            if (req_v0) chk("r_req_addr", req_a0, exp_pc);
            if (ov0) begin
                chk("r_out_pc", opc0, exp_pc);
                chk("r_out_inst", oi0, memf(exp_pc));
            end
            if (st_valid && !redir) begin
                chk("r_stable_v", ov0, 1);
                chk("r_stable_pc", opc0, st_pc);
                chk("r_stable_inst", oi0, st_inst);
            end

            acc = req_v0 & rdy;
            hs  = ov0 & ordy;
            if (p_valid) begin
                if (p_left == 0) p_valid = 1'b0;
                else p_left--;
            end
            if (acc) begin
                p_valid = 1'b1;
                p_addr  = req_a0;
                p_left  = $urandom_range(0, 2);
            end
            st_valid = ov0 & ~ordy;
            st_pc    = opc0;
            st_inst  = oi0;
            stall++;
            if (redir) begin
                exp_pc = {rpc[31:2], 2'b00};
                stall  = 0;
            end else if (hs) begin
                exp_pc = exp_pc + 32'd4;
                nhs++;
                stall  = 0;
            end
            if (stall > 200) begin
                total++;
                bad++;
                $error("FAIL r_progress: got %0d idle cycles want <=200", stall);
                break;
            end
        end
        chk("r_min_handshakes", 32'(nhs >= 100), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
